// File: rtl/sdr_sched_pkg.sv
// Shared types for the TX frame scheduler: FSM states, I/Q sample struct, sizing helper.
package sdr_sched_pkg;

    localparam int DEF_IQ_W = 12;

    typedef enum logic [1:0] {IDLE, HDR, PAY, GUARD} sched_state_e;

    typedef struct packed {
        logic [DEF_IQ_W-1:0] i;
        logic [DEF_IQ_W-1:0] q;
    } iq_sample_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/iq_out_reg.sv
// Registered valid/ready output slot; holds valid and data while downstream stalls.
module iq_out_reg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         load,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    assign load = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Sequences header, payload and zero guard samples into one I/Q stream.
// Define TX_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module tx_frame_scheduler
    import sdr_sched_pkg::*;
#(
    parameter int IQ_W      = DEF_IQ_W,
    parameter int HDR_LEN   = 64,
    parameter int MAX_PAY   = 4096,
    parameter int GUARD_LEN = 16,
    localparam int LEN_W    = $clog2(MAX_PAY + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [LEN_W-1:0] pay_len,
    input  logic            hdr_valid,
    output logic            hdr_ready,
    input  logic [IQ_W-1:0] hdr_i,
    input  logic [IQ_W-1:0] hdr_q,
    input  logic            pay_valid,
    output logic            pay_ready,
    input  logic [IQ_W-1:0] pay_i,
    input  logic [IQ_W-1:0] pay_q,
    output logic            out_valid,
    output logic [IQ_W-1:0] out_i,
    output logic [IQ_W-1:0] out_q,
    input  logic            out_ready,
`ifdef TX_FRAME_CNT_EN
    output logic [15:0]     frame_cnt,
`endif
    output logic            busy,
    output logic            frame_start
);

    localparam int CNT_W = $clog2(max3(HDR_LEN, MAX_PAY, GUARD_LEN) + 1);

    sched_state_e       state;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   len;
    logic               load, beat, last, to_end, start;
    logic [2*IQ_W-1:0]  sel_data;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = (pay_len > LEN_W'(MAX_PAY)) ? LEN_W'(MAX_PAY) : pay_len;
    assign hdr_ready   = (state == HDR) && load;
    assign pay_ready   = (state == PAY) && load;

    always_comb begin
        beat     = 1'b0;
        last     = 1'b0;
        sel_data = '0;
        case (state)
            HDR: begin
                beat     = hdr_valid && load;
                last     = (cnt == CNT_W'(HDR_LEN - 1));
                sel_data = {hdr_i, hdr_q};
            end
            PAY: begin
                beat     = pay_valid && load;
                last     = (cnt == CNT_W'(len) - CNT_W'(1));
                sel_data = {pay_i, pay_q};
            end
            GUARD: begin
                beat = load;
                last = (cnt == CNT_W'(GUARD_LEN - 1));
            end
            default: ;
        endcase
    end

    // Frame is over after the guard, or earlier when there is no guard to send.
    assign to_end = beat && last &&
                    ((state == GUARD) ||
                     ((GUARD_LEN == 0) && ((state == PAY) || ((state == HDR) && (len == '0)))));
    assign start  = enable && ((state == IDLE) || to_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
`ifdef TX_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            if (start) begin
                state       <= HDR;
                cnt         <= '0;
                len         <= len_clamped;
                busy        <= 1'b1;
                frame_start <= 1'b1;
`ifdef TX_FRAME_CNT_EN
                frame_cnt   <= frame_cnt + 16'd1;
`endif
            end else if (to_end) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else if (beat && last) begin
                cnt   <= '0;
                state <= ((state == HDR) && (len != '0)) ? PAY : GUARD;
            end else if (beat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    iq_out_reg #(.W(2 * IQ_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat),
        .in_data   (sel_data),
        .load      (load),
        .out_valid (out_valid),
        .out_data  ({out_i, out_q}),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized bench: frame-level model of expected output samples vs. the scheduler.
module tb_tx_frame_scheduler;
    import sdr_sched_pkg::*;

    localparam int HDR_LEN = 4, GUARD_LEN = 2, MAX_PAY = 4096;
    localparam int LEN_W = $clog2(MAX_PAY + 1);

    logic clk = 0, rst = 1, enable = 0;
    logic [LEN_W-1:0] pay_len = '0;
    logic hdr_valid = 0, pay_valid = 0, out_ready = 0;
    logic hdr_ready, pay_ready, out_valid, busy, frame_start;
    logic [11:0] hdr_i = 0, hdr_q = 0, pay_i = 0, pay_q = 0, out_i, out_q;
`ifdef TX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    tx_frame_scheduler #(.IQ_W(12), .HDR_LEN(HDR_LEN), .MAX_PAY(MAX_PAY), .GUARD_LEN(GUARD_LEN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pay_len(pay_len),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_i(hdr_i), .hdr_q(hdr_q),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_i(pay_i), .pay_q(pay_q),
        .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .out_ready(out_ready),
`ifdef TX_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .busy(busy), .frame_start(frame_start)
    );

    int checks = 0, errors = 0;
    int ncyc = 0, nstart = 0, hidx = 0, pidx = 0, hexp = 0, pexp = 0, pfr = 0;
    int first_hdr = -1, first_out = -1, starts_since_rst = 0;
    bit rnd = 0, cfg_en = 0, prev_stall = 0, saw_pay_ready = 0;
    logic [LEN_W-1:0] cfg_len = '0;
    iq_sample_t prev_data;
    iq_sample_t expq[$];
    int start_cyc[$];

    function automatic iq_sample_t hval(input int n);
        iq_sample_t s;
        s.i = 12'(n);
        s.q = 12'(n * 5 + 1);
        return s;
    endfunction

    function automatic iq_sample_t pval(input int n);
        iq_sample_t s;
        s.i = 12'(n * 7 + 100);
        s.q = 12'(n ^ 'h5A5);
        return s;
    endfunction

    // A frame is HDR_LEN header samples, min(len,MAX_PAY) payload samples, GUARD_LEN zeros.
    task automatic push_frame(input int len);
        int n;
        n = (len > MAX_PAY) ? MAX_PAY : len;
        for (int k = 0; k < HDR_LEN; k++) expq.push_back(hval(hexp++));
        for (int k = 0; k < n; k++) expq.push_back(pval(pexp++));
        for (int k = 0; k < GUARD_LEN; k++) expq.push_back('0);
    endtask

    task automatic tick();
        iq_sample_t got, e;
        @(negedge clk);
        ncyc++;
        if (frame_start) begin
            nstart++;
            starts_since_rst++;
            start_cyc.push_back(ncyc);
            push_frame(int'(pay_len));
        end
        enable    = cfg_en;
        pay_len   = cfg_len;
        hdr_valid = rnd ? ($urandom_range(9) < 7) : 1'b1;
        pay_valid = rnd ? ($urandom_range(9) < 7) : 1'b1;
        out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        {hdr_i, hdr_q} = hval(hidx);
        {pay_i, pay_q} = pval(pidx);
        #1;
        got = {out_i, out_q};
        if (pay_ready) saw_pay_ready = 1;
        if (prev_stall) begin
            checks++;
            if (!out_valid || got !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h", out_valid, got, prev_data);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (first_out < 0) first_out = ncyc;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL extra_sample: got %h, required no sample", got);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sample: got %h required %h", got, e);
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = got;
        if (hdr_valid && hdr_ready) begin
            if (first_hdr < 0) first_hdr = ncyc;
            hidx++;
        end
        if (pay_valid && pay_ready) begin
            pidx++;
            pfr++;
        end
    endtask

    task automatic start_frame(input int len);
        int n0;
        cfg_len = LEN_W'(len);
        cfg_en  = 1;
        n0 = nstart;
        pfr = 0;
        for (int k = 0; k < 40 && nstart == n0; k++) tick();
        cfg_en = 0;
        checks++;
        if (nstart == n0) begin
            errors++;
            $display("FAIL start_timeout: frame_start not seen, required within 40 cycles");
        end
    endtask

    task automatic run_idle(input int max);
        int k;
        cfg_en = 0;
        for (k = 0; k < max && (busy || out_valid || expq.size() != 0); k++) tick();
        checks++;
        if (busy || out_valid || expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0b pending=%0d required idle", busy, expq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        checks += 6;
        if (out_valid !== 0) begin errors++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
        if ({out_i, out_q} !== 24'h0) begin errors++; $display("FAIL rst_out_data: %h required 0", {out_i, out_q}); end
        if (busy !== 0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
        if (frame_start !== 0) begin errors++; $display("FAIL rst_frame_start: %b required 0", frame_start); end
        if (hdr_ready !== 0) begin errors++; $display("FAIL rst_hdr_ready: %b required 0", hdr_ready); end
        if (pay_ready !== 0) begin errors++; $display("FAIL rst_pay_ready: %b required 0", pay_ready); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_frame();
        rnd = 0;
        first_hdr = -1;
        first_out = -1;
        start_frame(3);
        run_idle(100);
        checks += 2;
        if (first_out - first_hdr !== 1) begin
            errors++;
            $display("FAIL first_latency: %0d cycles required 1", first_out - first_hdr);
        end
        if (pfr !== 3) begin errors++; $display("FAIL single_pay_count: %0d required 3", pfr); end
    endtask

    task automatic test_back_to_back();
        rnd = 0;
        cfg_len = 3;
        cfg_en = 1;
        start_cyc.delete();
        for (int k = 0; k < 60 && start_cyc.size() < 5; k++) tick();
        cfg_en = 0;
        checks++;
        if (start_cyc.size() < 5) begin
            errors++;
            $display("FAIL b2b_starts: %0d frame starts required 5", start_cyc.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (start_cyc[k] - start_cyc[k-1] !== 9) begin
                    errors++;
                    $display("FAIL b2b_interval: %0d cycles required 9", start_cyc[k] - start_cyc[k-1]);
                end
            end
        end
        run_idle(100);
    endtask

    task automatic test_random_stall();
        rnd = 1;
        start_frame(3);
        run_idle(300);
        checks++;
        if (pfr !== 3) begin errors++; $display("FAIL rand_pay_count: %0d required 3", pfr); end
        for (int f = 0; f < 6; f++) begin
            start_frame($urandom_range(12));
            run_idle(400);
        end
        // enable held while pay_len wanders every cycle
        cfg_en = 1;
        for (int k = 0; k < 200; k++) begin
            cfg_len = LEN_W'($urandom_range(10));
            tick();
        end
        run_idle(400);
        rnd = 0;
    endtask

    task automatic test_len_edges();
        rnd = 0;
        saw_pay_ready = 0;
        start_frame(0);
        run_idle(50);
        checks += 2;
        if (pfr !== 0) begin errors++; $display("FAIL len0_pay_count: %0d required 0", pfr); end
        if (saw_pay_ready !== 0) begin errors++; $display("FAIL len0_pay_ready: seen 1 required 0"); end
        start_frame(5000);
        run_idle(5000);
        checks++;
        if (pfr !== 4096) begin errors++; $display("FAIL clamp_pay_count: %0d required 4096", pfr); end
        start_frame(3);
        cfg_len = 10;
        run_idle(50);
        checks++;
        if (pfr !== 3) begin errors++; $display("FAIL midframe_len: %0d required 3", pfr); end
    endtask

    task automatic test_async_reset();
        int k;
        rnd = 0;
        start_frame(8);
        for (k = 0; k < 40 && pfr < 2; k++) tick();
        @(posedge clk);
        #2 rst = 1;
        #1;
        checks += 3;
        if (out_valid !== 0) begin errors++; $display("FAIL arst_out_valid: %b required 0", out_valid); end
        if (busy !== 0) begin errors++; $display("FAIL arst_busy: %b required 0", busy); end
        if (pay_ready !== 0) begin errors++; $display("FAIL arst_pay_ready: %b required 0", pay_ready); end
        // the interrupted frame and any pending output sample are gone
        expq.delete();
        prev_stall = 0;
        hexp = hidx;
        pexp = pidx;
        starts_since_rst = 0;
        enable = 1;
        cfg_en = 1;
        cfg_len = 2;
        @(negedge clk);
        rst = 0;
        first_out = -1;
        k = nstart;
        for (int j = 0; j < 10 && nstart == k; j++) tick();
        cfg_en = 0;
        run_idle(100);
        checks++;
        if (nstart == k) begin errors++; $display("FAIL arst_restart: no frame_start required one"); end
    endtask

`ifdef TX_FRAME_CNT_EN
    task automatic test_frame_cnt();
        checks++;
        if (frame_cnt !== 16'(starts_since_rst)) begin
            errors++;
            $display("FAIL frame_cnt: %0d required %0d", frame_cnt, starts_since_rst);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_stall();
        test_len_edges();
        test_async_reset();
`ifdef TX_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
